// File: rtl/gs_butterfly_pipe.sv
// Gentleman-Sande inverse NTT butterfly, three register stages.
// Optional merged halving (x * 2^-1 mod q) for final n^-1 scaling.
module gs_butterfly_pipe #(
  parameter int data_width = 64,
  parameter int modulo     = 7681
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic [data_width-1:0] tw_factor,
  input  logic                  half_en,
  output logic [data_width-1:0] u_out,
  output logic [data_width-1:0] v_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           bf_count
);

  localparam int W = data_width;
  localparam logic [W-1:0]   Q  = W'(modulo);
  localparam logic [W:0]     QE = (W+1)'(modulo);
  localparam logic [2*W-1:0] QW = (2*W)'(modulo);

  // x < q < 2^(W-1), so x + q never overflows W bits
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W-1:0] t;
    t = x[0] ? x + Q : x;
    return t >> 1;
  endfunction

  logic           en;
  logic           v1, v2;
  logic [W-1:0]   u1, d1, tw1;
  logic           h1, h2;
  logic [W-1:0]   u2;
  logic [2*W-1:0] p2;

  logic [W:0]     sum_raw;
  logic [W:0]     sum_sub;
  logic [W-1:0]   sum_mod;
  logic [W-1:0]   diff_mod;
  logic [W-1:0]   v_red;
  logic [W-1:0]   u_fin;
  logic [W-1:0]   v_fin;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    sum_raw  = {1'b0, a} + {1'b0, b};
    sum_sub  = sum_raw - QE;
    sum_mod  = (sum_raw >= QE) ? sum_sub[W-1:0] : sum_raw[W-1:0];
    diff_mod = (a < b) ? (a - b + Q) : (a - b);
  end

  always_comb begin
    v_red = W'(p2 % QW);
    u_fin = h2 ? halve(u2) : u2;
    v_fin = h2 ? halve(v_red) : v_red;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1    <= '0;
      d1    <= '0;
      tw1   <= '0;
      h1    <= 1'b0;
      u2    <= '0;
      p2    <= '0;
      h2    <= 1'b0;
      u_out <= '0;
      v_out <= '0;
    end else if (en) begin
      u1    <= sum_mod;
      d1    <= diff_mod;
      tw1   <= tw_factor;
      h1    <= half_en;
      u2    <= u1;
      p2    <= {{W{1'b0}}, d1} * {{W{1'b0}}, tw1};
      h2    <= h1;
      u_out <= u_fin;
      v_out <= v_fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bf_count <= '0;
    else if (out_valid && out_ready && !flush)
      bf_count <= bf_count + 16'd1;
  end

endmodule

// File: doc/gs_butterfly_pipe.md
GS_BUTTERFLY_PIPE -- requirements
Module: gs_butterfly_pipe

Interface
REQ-001 Parameter data_width, default 64: width of coefficient, twiddle and output words.
REQ-002 Parameter modulo, default 7681: prime q for all modular arithmetic; 2 < q < 2^(data_width-1), q odd.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear of all pipeline valid bits.
REQ-006 in_valid  input  1  a, b, tw_factor, half_en are presented.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 a, b  input  data_width each  butterfly operands, each < q.
REQ-009 tw_factor  input  data_width  inverse twiddle factor, < q.
REQ-010 half_en  input  1  multiply both results by 2^-1 mod q, for merged n^-1 scaling.
REQ-011 u_out, v_out  output  data_width each  butterfly results.
REQ-012 out_valid  output  1  u_out and v_out hold a result.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 bf_count  output  16  number of completed output transfers.

Function
REQ-015 Block SHALL compute the Gentleman-Sande inverse butterfly: u = (a+b) mod q, v = ((a-b) mod q * tw_factor) mod q.
REQ-016 When half_en = 1, block SHALL output u*2^-1 mod q and v*2^-1 mod q: x even gives x/2; x odd gives (x+q)/2.
REQ-017 half_en SHALL be captured with its operands and travel with them through the pipeline.
REQ-018 Pipeline SHALL have 3 register stages:
- S1: modular sum and difference, using a+b-q if a+b >= q and a-b+q if a < b.
- S2: full 2*data_width product of diff and tw_factor.
- S3: reduction of the product mod q, then optional halving of both values, into the output registers.
REQ-019 Global advance enable SHALL be en = !out_valid || out_ready; all stages and their valid bits SHALL update only when en = 1.
REQ-020 in_ready SHALL equal en, with no combinational dependence on in_valid.
REQ-021 An input transfer SHALL occur when in_valid && in_ready; a result SHALL be presented exactly 3 enabled cycles later.
REQ-022 An output transfer SHALL occur when out_valid && out_ready. While out_valid && !out_ready, u_out, v_out and out_valid SHALL hold stable.
REQ-023 Back-to-back inputs with out_ready held at 1 SHALL give throughput of 1 butterfly per cycle.
REQ-024 Results SHALL leave in input order; no transfer SHALL be dropped or duplicated.
REQ-025 bf_count SHALL increment by 1 on each output transfer and wrap from 65535 to 0.
REQ-026 flush = 1 SHALL clear all stage valid bits and out_valid on the next edge. It SHALL take priority over in_valid in that cycle and SHALL leave bf_count unchanged.
REQ-027 All outputs SHALL be < q whenever out_valid = 1.

Reset
REQ-028 On rst_n = 0, block SHALL immediately clear all valid bits, out_valid, u_out, v_out and bf_count to 0.
REQ-029 On rst_n = 0, in_ready SHALL read 1.
REQ-030 Reset mid-operation SHALL discard all in-flight butterflies; no result SHALL appear after release.
REQ-031 First input SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (q = 7681)
REQ-032 a=100, b=50, tw=2, half_en=0, out_ready=1 -> 3 cycles later u=150, v=100, bf_count=1.
REQ-033 a=10, b=20, tw=1 -> u=30, v=7671 (negative difference wraps). a=7680, b=7680, tw=5 -> u=7679, v=0.
REQ-034 a=3, b=0, tw=1, half_en=1 -> u=3842, v=3842. a=4, b=2, tw=3, half_en=1 -> u=3, v=3.
REQ-035 Stream of 8 inputs; out_ready held 0 for 5 cycles mid-stream -> in_ready=0 during the stall; outputs held stable; all 8 results in order; bf_count=8.
REQ-036 Reset asserted with 2 butterflies in flight -> out_valid=0 and bf_count=0 at once; no output after release. flush with 3 in flight -> out_valid=0 next cycle; bf_count unchanged.
